// File: rtl/multi_chan_sub_pkg.sv
// Shared types and helpers for the multi-channel notification checker.
package multi_chan_sub_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {R_NONE, R_PASS, R_FAIL, R_UNEXP} t_result;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sub_chan_queue.sv
// One checker channel: expected-message FIFO, head compare and idle timeout timer.
module sub_chan_queue
  import multi_chan_sub_pkg::*;
#(
  parameter int p_msg_bits = 32,
  parameter int p_depth    = 8,
  parameter int p_timeout  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [p_msg_bits-1:0] push_msg_i,
  input  logic                  val_i,
  input  logic [p_msg_bits-1:0] msg_i,
  output logic                  full_o,
  output logic                  empty_o,
  output t_result               result_o,
  output logic                  timeout_hit_o
);

  localparam int AW = $clog2(p_depth);
  localparam int TW = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;
  localparam logic [TW-1:0] TO_MAX  = TW'(p_timeout);
  localparam logic [TW-1:0] TO_LAST = TW'((p_timeout > 0) ? p_timeout - 1 : 0);

  logic [p_msg_bits-1:0] mem_q [p_depth];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  do_push, do_pop;
  logic [p_msg_bits-1:0] head;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = val_i && !empty_o;

  always_comb begin
    result_o = R_NONE;
    if (val_i) begin
      if (empty_o)              result_o = R_UNEXP;
      else if (msg_i == head)   result_o = R_PASS;
      else                      result_o = R_FAIL;
    end
  end

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Timer saturates at the limit; the hit pulse fires on the edge it gets there.
  always_comb begin
    timer_d = timer_q;
    if (p_timeout == 0 || empty_o || val_i) timer_d = '0;
    else if (timer_q != TO_MAX)             timer_d = timer_q + 1'b1;
  end

  assign timeout_hit_o = (p_timeout != 0) && !empty_o && !val_i && (timer_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      timer_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      timer_q  <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_msg_i;
  end

endmodule

// File: rtl/multi_chan_sub_checker.sv
// N-channel notification checker: push steering, pass/fail counting, sticky error capture.
// Optional text trace of channel activity when MULTI_CHAN_SUB_TRACE_EN is defined.
module multi_chan_sub_checker
  import multi_chan_sub_pkg::*;
#(
  parameter int p_msg_bits = 32,
  parameter int p_num_chan = 4,
  parameter int p_depth    = 8,
  parameter int p_timeout  = 64,
  localparam int CW = (p_num_chan > 1) ? $clog2(p_num_chan) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             exp_val,
  output logic                             exp_rdy,
  input  logic [CW-1:0]                    exp_chan,
  input  logic [p_msg_bits-1:0]            exp_msg,
  input  logic [p_num_chan-1:0]            val,
  input  logic [p_num_chan*p_msg_bits-1:0] msg,
  output logic                             idle,
  output logic                             err,
  output logic [CW-1:0]                    err_chan,
  output logic                             timeout,
  output logic [CNT_W-1:0]                 pass_count,
  output logic [CNT_W-1:0]                 fail_count
`ifdef MULTI_CHAN_SUB_TRACE_EN
  ,
  output string                            trace
`endif
);

  logic [p_num_chan-1:0] full, empty, push_vec, to_hit, chan_err;
  t_result               res [p_num_chan];

  logic [CNT_W-1:0] pass_inc, fail_inc;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             err_q, err_d, timeout_q, timeout_d;
  logic [CW-1:0]    err_chan_q, err_chan_d, first_err;

  for (genvar c = 0; c < p_num_chan; c++) begin : g_chan
    sub_chan_queue #(
      .p_msg_bits(p_msg_bits),
      .p_depth   (p_depth),
      .p_timeout (p_timeout)
    ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push_vec[c]),
      .push_msg_i   (exp_msg),
      .val_i        (val[c]),
      .msg_i        (msg[c*p_msg_bits +: p_msg_bits]),
      .full_o       (full[c]),
      .empty_o      (empty[c]),
      .result_o     (res[c]),
      .timeout_hit_o(to_hit[c])
    );
  end

  // Out-of-range channel indices are never ready, so they cannot push.
  always_comb begin
    exp_rdy  = 1'b0;
    push_vec = '0;
    for (int c = 0; c < p_num_chan; c++) begin
      if (exp_chan == CW'(c)) begin
        exp_rdy     = !full[c];
        push_vec[c] = exp_val && !full[c];
      end
    end
  end

  assign idle = &empty;

  always_comb begin
    pass_inc  = '0;
    fail_inc  = '0;
    chan_err  = '0;
    first_err = '0;
    for (int c = 0; c < p_num_chan; c++) begin
      if (res[c] == R_PASS) pass_inc = pass_inc + 1'b1;
      if (res[c] == R_FAIL || res[c] == R_UNEXP) begin
        fail_inc    = fail_inc + 1'b1;
        chan_err[c] = 1'b1;
      end
      if (to_hit[c]) chan_err[c] = 1'b1;
    end
    for (int c = p_num_chan - 1; c >= 0; c--) begin
      if (chan_err[c]) first_err = CW'(c);
    end
  end

  always_comb begin
    pass_d     = sat_add(pass_q, pass_inc);
    fail_d     = sat_add(fail_q, fail_inc);
    err_d      = err_q || (|chan_err);
    timeout_d  = timeout_q || (|to_hit);
    err_chan_d = err_chan_q;
    if (!err_q && (|chan_err)) err_chan_d = first_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q     <= '0;
      fail_q     <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      err_chan_q <= '0;
    end else begin
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      err_chan_q <= err_chan_d;
    end
  end

  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign err        = err_q;
  assign timeout    = timeout_q;
  assign err_chan   = err_chan_q;

`ifdef MULTI_CHAN_SUB_TRACE_EN
  localparam int HW = (p_msg_bits + 3) / 4;

  always_comb begin
    string s;
    s = "";
    for (int c = 0; c < p_num_chan; c++) begin
      if (c > 0) s = {s, "|"};
      if (val[c] && !empty[c]) begin
        s = {s, $sformatf("%h", msg[c*p_msg_bits +: p_msg_bits])};
      end else begin
        for (int k = 0; k < HW - 1; k++) s = {s, " "};
        if (val[c])        s = {s, "X"};
        else if (empty[c]) s = {s, "."};
        else               s = {s, " "};
      end
    end
    trace = s;
  end
`endif

endmodule

// File: tb/tb_multi_chan_sub_checker.sv
// Directed bench for multi_chan_sub_checker with default parameters (32b, 4 ch, depth 8, timeout 64).
module tb_multi_chan_sub_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic         exp_val;
  logic         exp_rdy;
  logic [1:0]   exp_chan;
  logic [31:0]  exp_msg;
  logic [3:0]   val;
  logic [127:0] msg;
  logic         idle, err, timeout;
  logic [1:0]   err_chan;
  logic [15:0]  pass_count, fail_count;
`ifdef MULTI_CHAN_SUB_TRACE_EN
  string        trace;
`endif

  int errors = 0;
  int checks = 0;

  multi_chan_sub_checker dut (
    .clk       (clk),
    .rst       (rst),
    .exp_val   (exp_val),
    .exp_rdy   (exp_rdy),
    .exp_chan  (exp_chan),
    .exp_msg   (exp_msg),
    .val       (val),
    .msg       (msg),
    .idle      (idle),
    .err       (err),
    .err_chan  (err_chan),
    .timeout   (timeout),
    .pass_count(pass_count),
    .fail_count(fail_count)
`ifdef MULTI_CHAN_SUB_TRACE_EN
    ,
    .trace     (trace)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_idle"},  32'(idle),       32'd1);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_to"},    32'(timeout),    32'd0);
    check({tag, "_echan"}, 32'(err_chan),   32'd0);
    check({tag, "_pass"},  32'(pass_count), 32'd0);
    check({tag, "_fail"},  32'(fail_count), 32'd0);
  endtask

  initial begin
    exp_val  = 1'b0;
    exp_chan = '0;
    exp_msg  = '0;
    val      = '0;
    msg      = '0;
    do_reset();

    // Reset state
    check_reset_state("rst");
    check("rst_rdy", 32'(exp_rdy), 32'd1);

    // Single push then matching notification on ch0
    exp_val = 1'b1; exp_chan = 2'd0; exp_msg = 32'hDEAD_BEEF;
    tick();
    exp_val = 1'b0;
    check("t1_busy", 32'(idle), 32'd0);
    val = 4'b0001; msg[31:0] = 32'hDEAD_BEEF;
    tick();
    val = '0;
    check("t1_pass", 32'(pass_count), 32'd1);
    check("t1_fail", 32'(fail_count), 32'd0);
    check("t1_err",  32'(err),        32'd0);
    check("t1_idle", 32'(idle),       32'd1);

    // Match then mismatch on ch2
    do_reset();
    exp_val = 1'b1; exp_chan = 2'd2; exp_msg = 32'h1;
    tick();
    exp_msg = 32'h2;
    tick();
    exp_val = 1'b0;
    val = 4'b0100; msg = '0; msg[95:64] = 32'h1;
    tick();
    check("t2_pass_a", 32'(pass_count), 32'd1);
    check("t2_err_a",  32'(err),        32'd0);
    msg[95:64] = 32'h3;
    tick();
    val = '0;
    check("t2_pass",  32'(pass_count), 32'd1);
    check("t2_fail",  32'(fail_count), 32'd1);
    check("t2_err",   32'(err),        32'd1);
    check("t2_echan", 32'(err_chan),   32'd2);
    check("t2_idle",  32'(idle),       32'd1);

    // Fill ch1, overflow push dropped, drain in order
    do_reset();
    exp_val = 1'b1; exp_chan = 2'd1;
    for (int i = 0; i < 8; i++) begin
      exp_msg = 32'h100 + 32'(i);
      tick();
    end
    exp_val = 1'b0;
    check("t3_full_rdy", 32'(exp_rdy), 32'd0);
    exp_chan = 2'd0;
    #1;
    check("t3_other_rdy", 32'(exp_rdy), 32'd1);
    exp_chan = 2'd1; exp_val = 1'b1; exp_msg = 32'hBAD;
    tick();
    exp_val = 1'b0;
    check("t3_drop_fail", 32'(fail_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      val = 4'b0010; msg = '0; msg[63:32] = 32'h100 + 32'(i);
      tick();
    end
    val = '0;
    check("t3_pass", 32'(pass_count), 32'd8);
    check("t3_fail", 32'(fail_count), 32'd0);
    check("t3_rdy",  32'(exp_rdy),    32'd1);
    check("t3_idle", 32'(idle),       32'd1);
    val = 4'b0010; msg[63:32] = 32'hBAD;
    tick();
    val = '0;
    check("t3_unexp", 32'(fail_count), 32'd1);

    // Two simultaneous unexpected notifications
    do_reset();
    val = 4'b1001;
    tick();
    val = '0;
    check("t4_fail",  32'(fail_count), 32'd2);
    check("t4_pass",  32'(pass_count), 32'd0);
    check("t4_err",   32'(err),        32'd1);
    check("t4_echan", 32'(err_chan),   32'd0);
    check("t4_idle",  32'(idle),       32'd1);

    // Timeout on ch1, then asynchronous reset mid-run
    do_reset();
    exp_val = 1'b1; exp_chan = 2'd1; exp_msg = 32'hA5;
    tick();
    exp_val = 1'b0;
    repeat (63) tick();
    check("t5_to_early", 32'(timeout), 32'd0);
    check("t5_err_early", 32'(err),    32'd0);
    tick();
    check("t5_to",    32'(timeout),    32'd1);
    check("t5_err",   32'(err),        32'd1);
    check("t5_echan", 32'(err_chan),   32'd1);
    check("t5_fail",  32'(fail_count), 32'd0);
    check("t5_busy",  32'(idle),       32'd0);
    tick();
    check("t5_hold",  32'(timeout),    32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("t5_async");
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rdy", 32'(exp_rdy), 32'd1);

    // Same-cycle push and notify on a one-entry queue
    do_reset();
    exp_val = 1'b1; exp_chan = 2'd0; exp_msg = 32'h7;
    tick();
    exp_msg = 32'h8; val = 4'b0001; msg = '0; msg[31:0] = 32'h7;
    tick();
    exp_val = 1'b0; val = '0;
    check("t6_pass", 32'(pass_count), 32'd1);
    check("t6_fail", 32'(fail_count), 32'd0);
    check("t6_busy", 32'(idle),       32'd0);
    val = 4'b0001; msg[31:0] = 32'h8;
    tick();
    val = '0;
    check("t6_pass2", 32'(pass_count), 32'd2);
    check("t6_idle",  32'(idle),       32'd1);

    // Same-cycle push and notify on an empty queue: unexpected, push lands
    exp_val = 1'b1; exp_chan = 2'd3; exp_msg = 32'h33; val = 4'b1000; msg = '0;
    tick();
    exp_val = 1'b0; val = '0;
    check("t6e_fail", 32'(fail_count), 32'd1);
    check("t6e_echan", 32'(err_chan),  32'd3);
    check("t6e_busy", 32'(idle),       32'd0);
    val = 4'b1000; msg[127:96] = 32'h33;
    tick();
    val = '0;
    check("t6e_pass", 32'(pass_count), 32'd3);
    check("t6e_idle", 32'(idle),        32'd1);

    // fail_count saturation: 4 unexpected per cycle
    do_reset();
    val = 4'b1111;
    repeat (16383) tick();
    check("t7_near", 32'(fail_count), 32'hFFFC);
    tick();
    check("t7_sat", 32'(fail_count), 32'hFFFF);
    tick();
    val = '0;
    check("t7_hold", 32'(fail_count), 32'hFFFF);
    check("t7_pass", 32'(pass_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
